// File: rtl/uart_rx_seq_checker.sv
// Checks the byte stream from uart_rx against an incrementing (+1, wrapping) pattern.
// Tracks lock to the pattern and keeps saturating good/error counts.
module uart_rx_seq_checker #(
  parameter int unsigned DATA_BIT = 8,
  parameter int unsigned LOCK_ERR = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DATA_BIT-1:0] i_data,
  input  logic                i_valid,
  input  logic                i_frame_err,
  input  logic                i_clear,
  output logic                o_locked,
  output logic [DATA_BIT-1:0] o_expect,
  output logic [CNT_W-1:0]    o_good_cnt,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic                o_err_pulse,
  output logic [DATA_BIT-1:0] o_last_bad
);

  localparam int unsigned MISS_W = $clog2(LOCK_ERR + 1);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(LOCK_ERR);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [MISS_W-1:0]   miss, miss_next;
  logic [DATA_BIT-1:0] expect_next, last_bad_next;
  logic [CNT_W-1:0]    good_next, err_next;
  logic                pulse_next;
  logic [CNT_W-1:0]    good_inc, err_inc;

  // Saturating increments; counters hold at all-ones.
  assign good_inc = (o_good_cnt == CNT_MAX) ? o_good_cnt : o_good_cnt + CNT_W'(1);
  assign err_inc  = (o_err_cnt  == CNT_MAX) ? o_err_cnt  : o_err_cnt  + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= HUNT;
      miss        <= '0;
      o_locked    <= 1'b0;
      o_expect    <= '0;
      o_good_cnt  <= '0;
      o_err_cnt   <= '0;
      o_err_pulse <= 1'b0;
      o_last_bad  <= '0;
    end else begin
      state       <= state_next;
      miss        <= miss_next;
      o_locked    <= (state_next == TRACK);
      o_expect    <= expect_next;
      o_good_cnt  <= good_next;
      o_err_cnt   <= err_next;
      o_err_pulse <= pulse_next;
      o_last_bad  <= last_bad_next;
    end
  end

  always_comb begin
    state_next    = state;
    miss_next     = miss;
    expect_next   = o_expect;
    good_next     = o_good_cnt;
    err_next      = o_err_cnt;
    pulse_next    = 1'b0;
    last_bad_next = o_last_bad;

    // Clear wins over a same-cycle byte; that byte is dropped.
    if (i_clear) begin
      state_next    = HUNT;
      miss_next     = '0;
      good_next     = '0;
      err_next      = '0;
      last_bad_next = '0;
    end else if (i_valid) begin
      unique case (state)
        HUNT: begin
          if (!i_frame_err) begin
            expect_next = i_data + DATA_BIT'(1);
            good_next   = good_inc;
            miss_next   = '0;
            state_next  = TRACK;
          end else begin
            err_next      = err_inc;
            pulse_next    = 1'b1;
            last_bad_next = i_data;
          end
        end
        TRACK: begin
          expect_next = o_expect + DATA_BIT'(1);
          if (!i_frame_err && (i_data == o_expect)) begin
            good_next = good_inc;
            miss_next = '0;
          end else begin
            err_next      = err_inc;
            pulse_next    = 1'b1;
            last_bad_next = i_data;
            // A bad byte still consumes its pattern slot.
            if (miss + MISS_W'(1) == MISS_LIM) begin
              state_next = HUNT;
              miss_next  = '0;
            end else begin
              miss_next = miss + MISS_W'(1);
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

endmodule
